// File: rtl/keyb_repeat_ctrl.sv
// rtl/keyb_repeat_ctrl.sv - keypad keystroke pulse generator with optional auto-repeat
// Auto-repeat (HOLD delay, REPEAT period) is built only when KEYB_AUTOREPEAT_EN is defined.

module keyb_repeat_ctrl #(
   parameter int CODE_W     = 4,
   parameter int DELAY_CYC  = 25000000,
   parameter int PERIOD_CYC = 5000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable_filter,
   input  logic [CODE_W-1:0] key_code,
   output logic              enable_real,
   output logic [CODE_W-1:0] key_out,
   output logic              repeating
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   state_t            state;
   logic              ef_q;
   logic              ef_prev;
   logic [CODE_W-1:0] code_q;
   logic              press;
   logic              code_changed;

   assign press        = ef_q & ~ef_prev;
   assign code_changed = (code_q != key_out);

   generate
      if (DELAY_CYC < 2 || PERIOD_CYC < 2) begin : g_param_check
         $error("keyb_repeat_ctrl: DELAY_CYC and PERIOD_CYC must be 2 or more");
      end
   endgenerate

`ifdef KEYB_AUTOREPEAT_EN
   localparam int MAX_CYC = (DELAY_CYC > PERIOD_CYC) ? DELAY_CYC : PERIOD_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC);
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY_CYC - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYC - 1);

   logic [CNT_W-1:0] cnt;
   logic             terminal;

   assign terminal = (state == REPEAT) ? (cnt == PERIOD_LAST) : (cnt == DELAY_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         ef_q        <= 1'b0;
         ef_prev     <= 1'b0;
         code_q      <= '0;
         enable_real <= 1'b0;
         key_out     <= '0;
         repeating   <= 1'b0;
      end else begin
         ef_q        <= enable_filter;
         ef_prev     <= ef_q;
         code_q      <= key_code;
         enable_real <= 1'b0;
         case (state)
            IDLE: begin
               if (press) begin
                  enable_real <= 1'b1;
                  key_out     <= code_q;
                  cnt         <= '0;
                  state       <= HOLD;
               end
            end
            HOLD, REPEAT: begin
               // Release wins over a terminal count landing in the same cycle.
               if (!ef_q) begin
                  cnt       <= '0;
                  repeating <= 1'b0;
                  state     <= IDLE;
               end else if (code_changed && !enable_real) begin
                  enable_real <= 1'b1;
                  key_out     <= code_q;
                  cnt         <= '0;
                  repeating   <= 1'b0;
                  state       <= HOLD;
               end else if (terminal) begin
                  enable_real <= 1'b1;
                  cnt         <= '0;
                  repeating   <= 1'b1;
                  state       <= REPEAT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt       <= '0;
               repeating <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end
`else
   assign repeating = 1'b0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ef_q        <= 1'b0;
         ef_prev     <= 1'b0;
         code_q      <= '0;
         enable_real <= 1'b0;
         key_out     <= '0;
      end else begin
         ef_q        <= enable_filter;
         ef_prev     <= ef_q;
         code_q      <= key_code;
         enable_real <= 1'b0;
         case (state)
            IDLE: begin
               if (press) begin
                  enable_real <= 1'b1;
                  key_out     <= code_q;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               // HOLD is terminal here: only release or a new code moves it.
               if (!ef_q) begin
                  state <= IDLE;
               end else if (code_changed && !enable_real) begin
                  enable_real <= 1'b1;
                  key_out     <= code_q;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_keyb_repeat_ctrl.sv
// tb/tb_keyb_repeat_ctrl.sv - directed self-checking bench for keyb_repeat_ctrl
// Expectations follow KEYB_AUTOREPEAT_EN, matching whichever build of the design is compiled.

module tb_keyb_repeat_ctrl;

   localparam int CODE_W     = 4;
   localparam int DELAY_CYC  = 8;
   localparam int PERIOD_CYC = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              enable_filter = 1'b0;
   logic [CODE_W-1:0] key_code = '0;
   logic              enable_real;
   logic [CODE_W-1:0] key_out;
   logic              repeating;

   int n_cmp = 0;
   int n_bad = 0;

   int                cyc = 0;
   int                pulse_cyc[$];
   logic [CODE_W-1:0] pulse_key[$];
   logic              prev_er = 1'b0;
   int                consec = 0;

   keyb_repeat_ctrl #(
      .CODE_W     (CODE_W),
      .DELAY_CYC  (DELAY_CYC),
      .PERIOD_CYC (PERIOD_CYC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable_filter (enable_filter),
      .key_code      (key_code),
      .enable_real   (enable_real),
      .key_out       (key_out),
      .repeating     (repeating)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse log: cyc read at the falling edge is the number of the rising edge that made the pulse.
   always @(negedge clk) begin
      if (enable_real === 1'b1) begin
         pulse_cyc.push_back(cyc);
         pulse_key.push_back(key_out);
         if (prev_er === 1'b1) consec++;
      end
      prev_er = enable_real;
   end

   task automatic test_reset();
      reset = 1'b0;
      enable_filter = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (enable_real !== 1'b0) begin n_bad++; $display("FAIL reset_enable_real got %b want 0", enable_real); end
      n_cmp++; if (key_out !== 4'h0) begin n_bad++; $display("FAIL reset_key_out got %h want 0", key_out); end
      n_cmp++; if (repeating !== 1'b0) begin n_bad++; $display("FAIL reset_repeating got %b want 0", repeating); end
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_press();
      int base;
      pulse_cyc.delete(); pulse_key.delete();
      base = cyc;
      enable_filter = 1'b1; key_code = 4'h7;
      repeat (5) @(negedge clk);
      enable_filter = 1'b0;
      repeat (6) @(negedge clk);
      n_cmp++; if (pulse_cyc.size() !== 1) begin n_bad++; $display("FAIL single_count got %0d want 1", pulse_cyc.size()); end
      if (pulse_cyc.size() > 0) begin
         n_cmp++; if (pulse_cyc[0] !== base + 2) begin n_bad++; $display("FAIL single_latency got %0d want %0d", pulse_cyc[0] - base, 2); end
         n_cmp++; if (pulse_key[0] !== 4'h7) begin n_bad++; $display("FAIL single_key got %h want 7", pulse_key[0]); end
      end
      n_cmp++; if (key_out !== 4'h7) begin n_bad++; $display("FAIL single_key_out got %h want 7", key_out); end
      n_cmp++; if (repeating !== 1'b0) begin n_bad++; $display("FAIL single_repeating got %b want 0", repeating); end
   endtask

   task automatic test_long_hold();
      int base;
      int exp_c[$];
      pulse_cyc.delete(); pulse_key.delete();
      base = cyc;
`ifdef KEYB_AUTOREPEAT_EN
      enable_filter = 1'b1; key_code = 4'h3;
      exp_c = '{base + 2, base + 10, base + 14, base + 18, base + 22};
      repeat (9) @(negedge clk);
      n_cmp++; if (repeating !== 1'b0) begin n_bad++; $display("FAIL hold_repeating_early got %b want 0", repeating); end
      @(negedge clk);
      n_cmp++; if (repeating !== 1'b1) begin n_bad++; $display("FAIL hold_repeating_set got %b want 1", repeating); end
      repeat (14) @(negedge clk);
`else
      enable_filter = 1'b1; key_code = 4'h5;
      exp_c = '{base + 2};
      repeat (15) @(negedge clk);
      n_cmp++; if (repeating !== 1'b0) begin n_bad++; $display("FAIL hold_repeating_mid got %b want 0", repeating); end
      repeat (15) @(negedge clk);
`endif
      enable_filter = 1'b0;
      repeat (8) @(negedge clk);
      n_cmp++; if (pulse_cyc.size() !== exp_c.size()) begin n_bad++; $display("FAIL hold_count got %0d want %0d", pulse_cyc.size(), exp_c.size()); end
      for (int i = 0; i < exp_c.size() && i < pulse_cyc.size(); i++) begin
         n_cmp++; if (pulse_cyc[i] !== exp_c[i]) begin n_bad++; $display("FAIL hold_pulse%0d_cycle got %0d want %0d", i, pulse_cyc[i] - base, exp_c[i] - base); end
      end
      n_cmp++; if (repeating !== 1'b0) begin n_bad++; $display("FAIL hold_repeating_after got %b want 0", repeating); end
   endtask

   task automatic test_code_change();
      int base;
      int exp_c[$];
      logic [CODE_W-1:0] exp_k[$];
      pulse_cyc.delete(); pulse_key.delete();
      base = cyc;
`ifdef KEYB_AUTOREPEAT_EN
      exp_c = '{base + 2, base + 6, base + 14};
      exp_k = '{4'h1, 4'h9, 4'h9};
`else
      exp_c = '{base + 2, base + 6};
      exp_k = '{4'h1, 4'h9};
`endif
      enable_filter = 1'b1; key_code = 4'h1;
      repeat (4) @(negedge clk);
      key_code = 4'h9;
      repeat (12) @(negedge clk);
      enable_filter = 1'b0;
      repeat (6) @(negedge clk);
      n_cmp++; if (pulse_cyc.size() !== exp_c.size()) begin n_bad++; $display("FAIL change_count got %0d want %0d", pulse_cyc.size(), exp_c.size()); end
      for (int i = 0; i < exp_c.size() && i < pulse_cyc.size(); i++) begin
         n_cmp++; if (pulse_cyc[i] !== exp_c[i]) begin n_bad++; $display("FAIL change_pulse%0d_cycle got %0d want %0d", i, pulse_cyc[i] - base, exp_c[i] - base); end
         n_cmp++; if (pulse_key[i] !== exp_k[i]) begin n_bad++; $display("FAIL change_pulse%0d_key got %h want %h", i, pulse_key[i], exp_k[i]); end
      end
   endtask

   task automatic test_release_at_terminal();
      int base;
      pulse_cyc.delete(); pulse_key.delete();
      base = cyc;
      enable_filter = 1'b1; key_code = 4'hc;
      repeat (16) @(negedge clk);
      enable_filter = 1'b0;
      repeat (6) @(negedge clk);
`ifdef KEYB_AUTOREPEAT_EN
      n_cmp++; if (pulse_cyc.size() !== 3) begin n_bad++; $display("FAIL term_count got %0d want 3", pulse_cyc.size()); end
      if (pulse_cyc.size() > 0) begin
         n_cmp++; if (pulse_cyc[pulse_cyc.size()-1] !== base + 14) begin n_bad++; $display("FAIL term_last_cycle got %0d want 14", pulse_cyc[pulse_cyc.size()-1] - base); end
      end
`else
      n_cmp++; if (pulse_cyc.size() !== 1) begin n_bad++; $display("FAIL term_count got %0d want 1", pulse_cyc.size()); end
`endif
      n_cmp++; if (repeating !== 1'b0) begin n_bad++; $display("FAIL term_repeating got %b want 0", repeating); end
   endtask

   task automatic test_back_to_back();
      int base;
      pulse_cyc.delete(); pulse_key.delete();
      base = cyc;
      enable_filter = 1'b1; key_code = 4'h2;
      repeat (3) @(negedge clk);
      enable_filter = 1'b0;
      @(negedge clk);
      enable_filter = 1'b1;
      repeat (3) @(negedge clk);
      enable_filter = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++; if (pulse_cyc.size() !== 2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", pulse_cyc.size()); end
      if (pulse_cyc.size() > 1) begin
         n_cmp++; if (pulse_cyc[0] !== base + 2) begin n_bad++; $display("FAIL b2b_first got %0d want 2", pulse_cyc[0] - base); end
         n_cmp++; if (pulse_cyc[1] !== base + 6) begin n_bad++; $display("FAIL b2b_second got %0d want 6", pulse_cyc[1] - base); end
      end
   endtask

   task automatic test_reset_mid_repeat();
      int base;
      enable_filter = 1'b1; key_code = 4'h6;
      repeat (12) @(negedge clk);
`ifdef KEYB_AUTOREPEAT_EN
      n_cmp++; if (repeating !== 1'b1) begin n_bad++; $display("FAIL rst_pre_repeating got %b want 1", repeating); end
`endif
      n_cmp++; if (key_out !== 4'h6) begin n_bad++; $display("FAIL rst_pre_key_out got %h want 6", key_out); end
      pulse_cyc.delete(); pulse_key.delete();
      reset = 1'b0;
      #1;
      n_cmp++; if (key_out !== 4'h0) begin n_bad++; $display("FAIL rst_async_key_out got %h want 0", key_out); end
      n_cmp++; if (repeating !== 1'b0) begin n_bad++; $display("FAIL rst_async_repeating got %b want 0", repeating); end
      n_cmp++; if (enable_real !== 1'b0) begin n_bad++; $display("FAIL rst_async_enable_real got %b want 0", enable_real); end
      @(negedge clk);
      reset = 1'b1;
      n_cmp++; if (pulse_cyc.size() !== 0) begin n_bad++; $display("FAIL rst_pulse_during got %0d want 0", pulse_cyc.size()); end
      base = cyc;
      repeat (5) @(negedge clk);
      n_cmp++; if (pulse_cyc.size() !== 1) begin n_bad++; $display("FAIL rst_fresh_count got %0d want 1", pulse_cyc.size()); end
      if (pulse_cyc.size() > 0) begin
         n_cmp++; if (pulse_cyc[0] !== base + 2) begin n_bad++; $display("FAIL rst_fresh_cycle got %0d want 2", pulse_cyc[0] - base); end
         n_cmp++; if (pulse_key[0] !== 4'h6) begin n_bad++; $display("FAIL rst_fresh_key got %h want 6", pulse_key[0]); end
      end
      enable_filter = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_long_hold();
      test_code_change();
      test_release_at_terminal();
      test_back_to_back();
      test_reset_mid_repeat();
      n_cmp++; if (consec !== 0) begin n_bad++; $display("FAIL consecutive_pulses got %0d want 0", consec); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
